timer_apb_ctrl: RTL and testbench

APB slave controller that configures and sequences the timer counter datapath. It holds the timer control, divider and halt registers and drives `timer_en`, `div_en`, `div_val` and `halt_req` into the counter-enable logic. It also generates the load and clear strobes for the 64-bit counter and returns the live counter value on reads. It sits between the APB interconnect and the counter/counter-enable blocks.

---
 rtl/timer_apb_ctrl_if.sv | 25 ++
 rtl/timer_apb_ctrl.sv | 168 ++++++++++++++++
 tb/tb_timer_apb_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_apb_ctrl_if.sv
// rtl/timer_apb_ctrl_if.sv - APB register bus between interconnect and the timer controller
`timescale 1ns/1ps
interface timer_apb_ctrl_if #(
   parameter int ADDR_W = 12
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [31:0]       pwdata;
   logic [3:0]        pstrb;
   logic [31:0]       prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/timer_apb_ctrl.sv
// rtl/timer_apb_ctrl.sv - APB slave holding timer control/divider/halt registers and counter load strobes
`timescale 1ns/1ps
module timer_apb_ctrl #(
   parameter int ADDR_W = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   timer_apb_ctrl_if.slave     apb,
   input  logic                i_debug_mode,
   input  logic [63:0]         i_cnt_val,
   output logic                o_timer_en,
   output logic                o_div_en,
   output logic [3:0]          o_div_val,
   output logic                o_halt_req,
   output logic                o_halt_ack,
   output logic                o_cnt_clr,
   output logic                o_cnt_wr_lo,
   output logic                o_cnt_wr_hi,
   output logic [31:0]         o_cnt_wdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [2:0] IDX_TCR   = 3'd0;
   localparam logic [2:0] IDX_TDR0  = 3'd1;
   localparam logic [2:0] IDX_TDR1  = 3'd2;
   localparam logic [2:0] IDX_THCSR = 3'd7;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_timer_en;
   logic        r_div_en;
   logic [3:0]  r_div_val;
   logic        r_halt_en;
   logic        r_halt_ack;
   logic        r_cnt_clr;
   logic        r_cnt_wr_lo;
   logic        r_cnt_wr_hi;
   logic [31:0] r_cnt_wdata;

   logic        w_resp;
   logic [2:0]  w_idx;
   logic        w_wr_commit;
   logic        w_full_strb;
   logic        w_tcr_wr;
   logic        w_new_en;
   logic        w_new_den;
   logic [3:0]  w_new_dval;
   logic        w_tcr_bad;
   logic        w_halt_req;
   logic [31:0] w_rdata;
   logic        w_unused_addr;

   // Entering WAIT on the setup phase places RESP in the second access cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (apb.psel) begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (apb.psel && apb.penable) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_resp        = (r_state == ST_RESP);
   assign w_idx         = apb.paddr[4:2];
   assign w_wr_commit   = w_resp & apb.pwrite;
   assign w_full_strb   = (apb.pstrb == 4'hF);
   assign w_tcr_wr      = w_wr_commit & (w_idx == IDX_TCR);
   assign w_unused_addr = ^{apb.paddr[ADDR_W-1:5], apb.paddr[1:0]};

   // Byte-lane merge of a TCR write; the whole write is rejected if it is illegal.
   always_comb begin
      w_new_en   = apb.pstrb[0] ? apb.pwdata[0]    : r_timer_en;
      w_new_den  = apb.pstrb[0] ? apb.pwdata[1]    : r_div_en;
      w_new_dval = apb.pstrb[1] ? apb.pwdata[11:8] : r_div_val;
      w_tcr_bad  = (w_new_dval > 4'd8) |
                   (r_timer_en & ((w_new_den != r_div_en) | (w_new_dval != r_div_val)));
   end

   always_comb begin
      w_rdata = 32'h0;
      case (w_idx)
         IDX_TCR:   w_rdata = {20'h0, r_div_val, 6'h0, r_div_en, r_timer_en};
         IDX_TDR0:  w_rdata = i_cnt_val[31:0];
         IDX_TDR1:  w_rdata = i_cnt_val[63:32];
         IDX_THCSR: w_rdata = {30'h0, r_halt_ack, r_halt_en};
         default:   w_rdata = 32'h0;
      endcase
   end

   assign apb.pready  = w_resp;
   assign apb.pslverr = w_tcr_wr & w_tcr_bad;
   assign apb.prdata  = (w_resp & ~apb.pwrite) ? w_rdata : 32'h0;

   assign w_halt_req  = r_halt_en & i_debug_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer_en  <= 1'b0;
         r_div_en    <= 1'b0;
         r_div_val   <= 4'd1;
         r_halt_en   <= 1'b0;
         r_halt_ack  <= 1'b0;
         r_cnt_clr   <= 1'b0;
         r_cnt_wr_lo <= 1'b0;
         r_cnt_wr_hi <= 1'b0;
         r_cnt_wdata <= 32'h0;
      end else begin
         r_cnt_clr   <= 1'b0;
         r_cnt_wr_lo <= 1'b0;
         r_cnt_wr_hi <= 1'b0;
         r_halt_ack  <= w_halt_req;
         if (w_tcr_wr && !w_tcr_bad) begin
            r_timer_en <= w_new_en;
            r_div_en   <= w_new_den;
            r_div_val  <= w_new_dval;
            r_cnt_clr  <= r_timer_en & ~w_new_en;
         end
         if (w_wr_commit && w_full_strb && (w_idx == IDX_TDR0)) begin
            r_cnt_wr_lo <= 1'b1;
         end
         if (w_wr_commit && w_full_strb && (w_idx == IDX_TDR1)) begin
            r_cnt_wr_hi <= 1'b1;
         end
         if (w_wr_commit && (w_idx == IDX_THCSR) && apb.pstrb[0]) begin
            r_halt_en <= apb.pwdata[0];
         end
         if (w_wr_commit) begin
            r_cnt_wdata <= apb.pwdata;
         end
      end
   end

   assign o_timer_en  = r_timer_en;
   assign o_div_en    = r_div_en;
   assign o_div_val   = r_div_val;
   assign o_halt_req  = w_halt_req;
   assign o_halt_ack  = r_halt_ack;
   assign o_cnt_clr   = r_cnt_clr;
   assign o_cnt_wr_lo = r_cnt_wr_lo;
   assign o_cnt_wr_hi = r_cnt_wr_hi;
   assign o_cnt_wdata = r_cnt_wdata;

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// tb/tb_timer_apb_ctrl.sv - self-checking bench for timer_apb_ctrl
`timescale 1ns/1ps
module tb_timer_apb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        debug_mode;
   logic [63:0] cnt_val;
   logic        timer_en, div_en, halt_req, halt_ack;
   logic [3:0]  div_val;
   logic        cnt_clr, cnt_wr_lo, cnt_wr_hi;
   logic [31:0] cnt_wdata;
   logic [5:0]  ctl;

   always #5 clk = ~clk;

   timer_apb_ctrl_if #(.ADDR_W(12)) apb ();

   timer_apb_ctrl #(.ADDR_W(12)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .apb          (apb),
      .i_debug_mode (debug_mode),
      .i_cnt_val    (cnt_val),
      .o_timer_en   (timer_en),
      .o_div_en     (div_en),
      .o_div_val    (div_val),
      .o_halt_req   (halt_req),
      .o_halt_ack   (halt_ack),
      .o_cnt_clr    (cnt_clr),
      .o_cnt_wr_lo  (cnt_wr_lo),
      .o_cnt_wr_hi  (cnt_wr_hi),
      .o_cnt_wdata  (cnt_wdata)
   );

   assign ctl = {div_val, div_en, timer_en};

   int n_total = 0;
   int n_pass  = 0;

   // Register image held by the reference model
   bit         m_en, m_den, m_halt;
   logic [3:0] m_dval;

   typedef struct {
      bit          wr;
      logic [11:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [63:0] cnt;
      logic [31:0] rd;
      bit          err;
      bit          clr;
      bit          lo;
      bit          hi;
      logic [5:0]  ctl;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
   endtask

   task automatic model_reset();
      m_en = 1'b0; m_den = 1'b0; m_dval = 4'd1; m_halt = 1'b0;
   endtask

   // Computes the response from the register map rules on a 32-bit register image.
   task automatic model_xfer(input bit wr, input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [63:0] cnt, input bit dbg,
                             output logic [31:0] rd, output bit err, output bit clr,
                             output bit lo, output bit hi);
      logic [31:0] img, mask, nimg;
      img  = {20'h0, m_dval, 6'h0, m_den, m_en};
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      rd = 32'h0; err = 1'b0; clr = 1'b0; lo = 1'b0; hi = 1'b0;
      if (!wr) begin
         case (addr[4:2])
            3'd0: rd = img;
            3'd1: rd = cnt[31:0];
            3'd2: rd = cnt[63:32];
            3'd7: rd = {30'h0, m_halt & dbg, m_halt};
            default: rd = 32'h0;
         endcase
      end else begin
         case (addr[4:2])
            3'd0: begin
               nimg = ((img & ~mask) | (data & mask)) & 32'h0000_0F03;
               if ((nimg[11:8] > 4'd8) || (m_en && (nimg[11:1] != img[11:1]))) begin
                  err = 1'b1;
               end else begin
                  clr    = m_en && !nimg[0];
                  m_en   = nimg[0];
                  m_den  = nimg[1];
                  m_dval = nimg[11:8];
               end
            end
            3'd1: lo = (strb == 4'hF);
            3'd2: hi = (strb == 4'hF);
            3'd7: if (strb[0]) m_halt = data[0];
            default: ;
         endcase
      end
   endtask

   task automatic run_xfer(input string tag, input bit wr, input logic [11:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, input logic [63:0] cnt,
                           input bit dbg, input logic [31:0] e_rd, input bit e_err, input bit e_clr,
                           input bit e_lo, input bit e_hi, input logic [5:0] e_ctl, input bit e_hreq);
      int n;
      bit got;
      logic [31:0] rd;
      logic er;
      @(posedge clk); #1;
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = addr;
      apb.pwdata = data; apb.pstrb = strb; cnt_val = cnt; debug_mode = dbg;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      n = 0; got = 1'b0; rd = 32'h0; er = 1'b0;
      while (!got && n < 6) begin
         n++;
         @(negedge clk);
         if (apb.pready) begin
            got = 1'b1; rd = apb.prdata; er = apb.pslverr;
         end
      end
      @(posedge clk); #1;
      apb.psel = 1'b0; apb.penable = 1'b0;
      chk({tag, " ready_cycle"}, n, 2);
      chk({tag, " prdata"}, rd, e_rd);
      chk({tag, " pslverr"}, er, e_err);
      @(negedge clk);
      chk({tag, " strobes"}, {cnt_clr, cnt_wr_lo, cnt_wr_hi}, {e_clr, e_lo, e_hi});
      chk({tag, " ctl"}, ctl, e_ctl);
      chk({tag, " halt_req"}, halt_req, e_hreq);
      if (e_lo || e_hi) chk({tag, " cnt_wdata"}, cnt_wdata, data);
      @(negedge clk);
      chk({tag, " strobe_width"}, {cnt_clr, cnt_wr_lo, cnt_wr_hi}, 3'b000);
   endtask

   task automatic model_run(input string tag, input bit wr, input logic [11:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [63:0] cnt, input bit dbg);
      logic [31:0] rd;
      bit err, clr, lo, hi;
      model_xfer(wr, addr, data, strb, cnt, dbg, rd, err, clr, lo, hi);
      run_xfer(tag, wr, addr, data, strb, cnt, dbg, rd, err, clr, lo, hi,
               {m_dval, m_den, m_en}, m_halt & dbg);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " pready"}, apb.pready, 1'b0);
      chk({tag, " pslverr"}, apb.pslverr, 1'b0);
      chk({tag, " prdata"}, apb.prdata, 32'h0);
      chk({tag, " ctl"}, ctl, 6'h04);
      chk({tag, " strobes"}, {cnt_clr, cnt_wr_lo, cnt_wr_hi}, 3'b000);
      chk({tag, " cnt_wdata"}, cnt_wdata, 32'h0);
      chk({tag, " halt"}, {halt_req, halt_ack}, 2'b00);
   endtask

   initial begin
      logic [31:0] t_rd;
      bit t_err, t_clr, t_lo, t_hi;
      int seen;

      vecs[0]  = '{1'b0, 12'h000, 32'h0,         4'h0, 64'h0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 6'h04};
      vecs[1]  = '{1'b1, 12'h000, 32'h0000_0302, 4'hF, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0E};
      vecs[2]  = '{1'b1, 12'h000, 32'h0000_0303, 4'hF, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0F};
      vecs[3]  = '{1'b1, 12'h000, 32'h0000_0503, 4'hF, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h0F};
      vecs[4]  = '{1'b1, 12'h000, 32'h0000_0302, 4'hF, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h0E};
      vecs[5]  = '{1'b1, 12'h000, 32'h0000_0900, 4'hF, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h0E};
      vecs[6]  = '{1'b1, 12'h008, 32'hDEAD_BEEF, 4'hF, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h0E};
      vecs[7]  = '{1'b1, 12'h008, 32'hDEAD_BEEF, 4'h3, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0E};
      vecs[8]  = '{1'b0, 12'h004, 32'h0, 4'h0, 64'h1234_5678_9ABC_DEF0, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0E};
      vecs[9]  = '{1'b0, 12'h008, 32'h0, 4'h0, 64'h1234_5678_9ABC_DEF0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0E};
      vecs[10] = '{1'b0, 12'h000, 32'h0,         4'h0, 64'h0, 32'h0000_0302, 1'b0, 1'b0, 1'b0, 1'b0, 6'h0E};
      vecs[11] = '{1'b1, 12'h000, 32'h0000_0800, 4'h2, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h22};
      vecs[12] = '{1'b0, 12'h000, 32'h0,         4'h0, 64'h0, 32'h0000_0802, 1'b0, 1'b0, 1'b0, 1'b0, 6'h22};
      vecs[13] = '{1'b0, 12'h010, 32'h0,         4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h22};
      vecs[14] = '{1'b1, 12'h014, 32'hFFFF_FFFF, 4'hF, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h22};
      vecs[15] = '{1'b1, 12'h004, 32'hCAFE_0001, 4'hF, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h22};
      vecs[16] = '{1'b1, 12'h000, 32'h0000_0000, 4'h1, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h20};
      vecs[17] = '{1'b1, 12'h000, 32'h0000_0FF1, 4'h1, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h21};
      vecs[18] = '{1'b1, 12'h000, 32'h0000_00F0, 4'h1, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h20};

      rst_n = 1'b0; debug_mode = 1'b0; cnt_val = 64'h0;
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
      apb.paddr = 12'h0; apb.pwdata = 32'h0; apb.pstrb = 4'h0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         model_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].cnt, 1'b0,
                    t_rd, t_err, t_clr, t_lo, t_hi);
         run_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
                  vecs[i].cnt, 1'b0, vecs[i].rd, vecs[i].err, vecs[i].clr, vecs[i].lo,
                  vecs[i].hi, vecs[i].ctl, 1'b0);
      end

      // psel drops in the WAIT cycle: transfer abandoned, nothing commits
      @(posedge clk); #1;
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
      apb.paddr = 12'h000; apb.pwdata = 32'h0000_0001; apb.pstrb = 4'hF;
      @(posedge clk); #1;
      apb.psel = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (apb.pready) seen++;
      end
      chk("abort ready_seen", seen, 0);
      chk("abort ctl", ctl, {m_dval, m_den, m_en});

      model_run("halt_wr", 1'b1, 12'h01C, 32'h1, 4'hF, 64'h0, 1'b0);
      @(posedge clk); #1;
      debug_mode = 1'b1;
      @(negedge clk);
      chk("halt same_cycle", {halt_req, halt_ack}, 2'b10);
      @(negedge clk);
      chk("halt ack_next", {halt_req, halt_ack}, 2'b11);
      model_run("thcsr_rd", 1'b0, 12'h01C, 32'h0, 4'h0, 64'h0, 1'b1);

      // Reset asserted while the FSM sits in WAIT
      @(posedge clk); #1;
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
      apb.paddr = 12'h000; apb.pwdata = 32'h0000_0001; apb.pstrb = 4'hF;
      @(posedge clk); #1;
      apb.penable = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_abort");
      apb.psel = 1'b0; apb.penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      model_run("post_rst", 1'b0, 12'h000, 32'h0, 4'h0, 64'h0, 1'b1);

      for (int i = 0; i < 250; i++) begin
         logic [11:0] a;
         logic [31:0] d;
         case ($urandom_range(0, 5))
            0, 1: a = 12'h000;
            2:    a = 12'h004;
            3:    a = 12'h008;
            4:    a = 12'h01C;
            default: a = 12'($urandom_range(0, 4095));
         endcase
         d = ($urandom_range(0, 3) != 0) ? ($urandom & 32'h0000_0F03) : $urandom;
         model_run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, d,
                   4'($urandom_range(0, 15)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
